mips_watchdog_timer: RTL and testbench

MIPS_WATCHDOG_TIMER -- requirements
Module: mips_watchdog_timer

---
 rtl/mips_wdt_pkg.sv | 18 +
 rtl/mips_wdt_counter.sv | 30 +++
 rtl/mips_watchdog_timer.sv | 142 ++++++++++++++
 tb/tb_mips_watchdog_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_wdt_pkg.sv
// Shared definitions for the MIPS watchdog timer: state encoding and pulse defaults.
package mips_wdt_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FIRE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_FIRE = FIRE
    } wdt_state_t;

    localparam int unsigned DEF_PULSE_CYCLES = 4;
    // Pulse counter width covers PULSE_CYCLES up to 15.
    localparam int unsigned PULSE_W = 4;

endpackage

// File: rtl/mips_wdt_counter.sv
// Loadable, saturating down-counter for the watchdog; never wraps below zero.
module mips_wdt_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    // Load has priority over decrement; decrement holds at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Zero flag straight off the count register.
    always_comb begin
        zero_c = (count == '0);
    end

endmodule

// File: rtl/mips_watchdog_timer.sv
// Watchdog timer armed by the wdt_set instruction; raises a CPU reset pulse on expiry.
// Optional macro MIPS_WDT_LOCK_EN: period is latched by the first nonzero strobe
// after reset, later strobes only kick the counter and cannot disable it.
module mips_watchdog_timer
    import mips_wdt_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wait_period_w_en,
    input  logic [WIDTH-1:0] i_wait_period,
    output logic             o_wdt_reset,
    output logic             o_timeout_sticky,
    output logic [WIDTH-1:0] o_count,
    output logic             o_armed
);

    wdt_state_t          state;
    wdt_state_t          state_n;
    logic [WIDTH-1:0]    period;
    logic [WIDTH-1:0]    period_n;
    logic [PULSE_W-1:0]  pulse_cnt;
    logic [PULSE_W-1:0]  pulse_cnt_n;
    logic                cnt_load;
    logic [WIDTH-1:0]    cnt_load_value;
    logic                cnt_dec;
    logic                cnt_zero_c;
`ifdef MIPS_WDT_LOCK_EN
    logic                locked;
    logic                locked_n;
`endif

    mips_wdt_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (o_count),
        .zero_c     (cnt_zero_c)
    );

    // State, period, pulse length and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state            <= S_IDLE;
            period           <= '0;
            pulse_cnt        <= '0;
            o_wdt_reset      <= 1'b0;
            o_timeout_sticky <= 1'b0;
            o_armed          <= 1'b0;
`ifdef MIPS_WDT_LOCK_EN
            locked           <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            period      <= period_n;
            pulse_cnt   <= pulse_cnt_n;
            o_wdt_reset <= (state_n == S_FIRE);
            o_armed     <= (state_n == S_RUN);
            if ((state_n == S_FIRE) && (state != S_FIRE)) begin
                o_timeout_sticky <= 1'b1;
            end
`ifdef MIPS_WDT_LOCK_EN
            locked      <= locked_n;
`endif
        end
    end

    // Next state and counter control; a strobe outranks expiry, FIRE ignores strobes.
    always_comb begin
        state_n        = state;
        period_n       = period;
        pulse_cnt_n    = pulse_cnt;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
`ifdef MIPS_WDT_LOCK_EN
        locked_n       = locked;
`endif
        case (state)
            S_IDLE, S_RUN: begin
                if (i_wait_period_w_en) begin
`ifdef MIPS_WDT_LOCK_EN
                    if (locked) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = period;
                        state_n        = S_RUN;
                    end else if (i_wait_period != '0) begin
                        period_n       = i_wait_period;
                        locked_n       = 1'b1;
                        cnt_load       = 1'b1;
                        cnt_load_value = i_wait_period;
                        state_n        = S_RUN;
                    end else begin
                        cnt_load       = 1'b1;
                        cnt_load_value = '0;
                        state_n        = S_IDLE;
                    end
`else
                    if (i_wait_period != '0) begin
                        period_n       = i_wait_period;
                        cnt_load       = 1'b1;
                        cnt_load_value = i_wait_period;
                        state_n        = S_RUN;
                    end else begin
                        cnt_load       = 1'b1;
                        cnt_load_value = '0;
                        state_n        = S_IDLE;
                    end
`endif
                end else if (state == S_RUN) begin
                    if (o_count == WIDTH'(1)) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = '0;
                        pulse_cnt_n    = PULSE_W'(PULSE_CYCLES - 1);
                        state_n        = S_FIRE;
                    end else if (!cnt_zero_c) begin
                        cnt_dec        = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                if (pulse_cnt == '0) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = period;
                    state_n        = S_RUN;
                end else begin
                    pulse_cnt_n    = pulse_cnt - PULSE_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_watchdog_timer.sv
// Directed self-checking bench for mips_watchdog_timer (WIDTH=32, PULSE_CYCLES=4).
module tb_mips_watchdog_timer;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [31:0] wval;
    logic        wdt_reset;
    logic        sticky;
    logic [31:0] count;
    logic        armed;

    int total;
    int bad;
    int min_cnt;
    int seen_rst;

    mips_watchdog_timer #(
        .WIDTH        (32),
        .PULSE_CYCLES (4)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_wait_period_w_en (wen),
        .i_wait_period      (wval),
        .o_wdt_reset        (wdt_reset),
        .o_timeout_sticky   (sticky),
        .o_count            (count),
        .o_armed            (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] v);
        wen  = 1'b1;
        wval = v;
        tick();
        wen  = 1'b0;
        wval = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        wen   = 1'b0;
        wval  = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_wdt", 32'(wdt_reset), 0);
        check_eq("rst_sticky", 32'(sticky), 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_armed", 32'(armed), 0);
        rst = 1'b1;

        // P=5: pulse on clocks 5..8, then back in RUN with count 5
        strobe(32'd5);
        check_eq("p5_load", count, 5);
        check_eq("p5_armed", 32'(armed), 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("p5_wdt_k%0d", k), 32'(wdt_reset), (k >= 5 && k <= 8) ? 1 : 0);
            if (k == 4) check_eq("p5_cnt_k4", count, 1);
            if (k == 5) check_eq("p5_sticky", 32'(sticky), 1);
            if (k == 9) begin
                check_eq("p5_reload", count, 5);
                check_eq("p5_rearmed", 32'(armed), 1);
            end
        end

        // Zero strobe disables: no pulse for 50 clocks
        strobe(32'd0);
        check_eq("z_armed", 32'(armed), 0);
        check_eq("z_count", count, 0);
        seen_rst = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (wdt_reset) seen_rst = 1;
        end
        check_eq("z_no_pulse", 32'(seen_rst), 0);
        check_eq("z_sticky_held", 32'(sticky), 1);

        // P=10 kicked every 8 clocks for 100 clocks
        do_reset();
        check_eq("kick_sticky_clr", 32'(sticky), 0);
        strobe(32'd10);
        min_cnt  = 10;
        seen_rst = 0;
        for (int c = 0; c < 100; c++) begin
            wen  = ((c % 8) == 7);
            wval = 32'd10;
            tick();
            wen  = 1'b0;
            if (wdt_reset) seen_rst = 1;
            if (int'(count) < min_cnt) min_cnt = int'(count);
        end
        check_eq("kick_no_pulse", 32'(seen_rst), 0);
        check_eq("kick_min_cnt", 32'(min_cnt), 3);
        check_eq("kick_sticky", 32'(sticky), 0);

        // P=3, re-strobe exactly when count==1
        strobe(32'd3);
        tick();
        tick();
        check_eq("race_cnt1", count, 1);
        strobe(32'd3);
        check_eq("race_reload", count, 3);
        check_eq("race_no_fire", 32'(wdt_reset), 0);
        check_eq("race_armed", 32'(armed), 1);
        tick();
        check_eq("race_dec", count, 2);

        // Expire, then reset during the 2nd FIRE cycle
        tick();
        check_eq("mid_cnt1", count, 1);
        tick();
        check_eq("mid_fire1", 32'(wdt_reset), 1);
        check_eq("mid_sticky", 32'(sticky), 1);
        check_eq("mid_cnt0", count, 0);
        tick();
        check_eq("mid_fire2", 32'(wdt_reset), 1);
        rst = 1'b0;
        tick();
        check_eq("mid_rst_wdt", 32'(wdt_reset), 0);
        check_eq("mid_rst_sticky", 32'(sticky), 0);
        check_eq("mid_rst_armed", 32'(armed), 0);
        rst = 1'b1;
        tick();
        check_eq("mid_idle_wdt", 32'(wdt_reset), 0);
        check_eq("mid_idle_cnt", count, 0);

        // P=1 fires next clock; strobes inside FIRE are ignored
        strobe(32'd1);
        check_eq("p1_load", count, 1);
        tick();
        check_eq("p1_fire", 32'(wdt_reset), 1);
        strobe(32'd7);
        check_eq("p1_ign_wdt", 32'(wdt_reset), 1);
        check_eq("p1_ign_cnt", count, 0);
        tick();
        tick();
        check_eq("p1_fire_last", 32'(wdt_reset), 1);
        tick();
        check_eq("p1_end_wdt", 32'(wdt_reset), 0);
        check_eq("p1_end_cnt", count, 1);
        check_eq("p1_end_armed", 32'(armed), 1);

        // Period lock behaviour (or plain reload without the lock)
        do_reset();
        strobe(32'd6);
        tick();
        tick();
        check_eq("lk_dec", count, 4);
        strobe(32'd20);
`ifdef MIPS_WDT_LOCK_EN
        check_eq("lk_reload", count, 6);
        strobe(32'd0);
        check_eq("lk_zero_armed", 32'(armed), 1);
        check_eq("lk_zero_cnt", count, 6);
`else
        check_eq("lk_reload", count, 20);
        strobe(32'd0);
        check_eq("lk_zero_armed", 32'(armed), 0);
        check_eq("lk_zero_cnt", count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
